fpnew_pipe_out_fifo: RTL and testbench

- Output-side result queue placed directly downstream of an operation group's datapath, which is fed by the input pipeline stage.
- Captures completed results (value, IEEE status flags, extension bit, tag, aux) and buffers up to Depth entries.
- Lets the datapath keep retiring results while the consumer (the FPU output arbiter) stalls.
- Valid/ready on both sides; synchronous flush; busy indication.

---
 rtl/fpnew_pkg.sv | 12 +
 rtl/fpnew_wrap_ptr.sv | 28 ++
 rtl/fpnew_pipe_out_fifo.sv | 109 ++++++++++
 tb/tb_fpnew_pipe_out_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - shared FPU types: IEEE exception status flags
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_wrap_ptr.sv
// rtl/fpnew_wrap_ptr.sv - modulo-Depth pointer counter with enable and synchronous clear
module fpnew_wrap_ptr #(
  parameter  int unsigned Depth = 2,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_clr,
  output logic [PtrW-1:0] o_ptr
);

  logic [PtrW-1:0] r_ptr;

  // Clear wins over advance so a flush never leaves a pointer mid-queue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PtrW'(Depth - 1)) ? '0 : r_ptr + PtrW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fpnew_pipe_out_fifo.sv
// rtl/fpnew_pipe_out_fifo.sv - result queue behind an FPU operation group datapath
module fpnew_pipe_out_fifo
  import fpnew_pkg::*;
#(
  parameter  int unsigned Width   = 32,
  parameter  int unsigned Depth   = 2,
  parameter  type         TagType = logic,
  parameter  type         AuxType = logic,
  localparam int unsigned FillW   = $clog2(Depth + 1),
  localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] result_i,
  input  status_t          status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  input  AuxType           aux_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output AuxType           aux_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [FillW-1:0] fill_o
);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             extension_bit;
    TagType           tag;
    AuxType           aux;
  } entry_t;

  entry_t           r_mem [Depth];
  logic [FillW-1:0] r_count;
  logic [PtrW-1:0]  w_wr_ptr;
  logic [PtrW-1:0]  w_rd_ptr;
  logic             w_push;
  logic             w_pop;
  logic             w_write;

  // Ready looks only at the registered count, so a full queue refuses a push
  // even while the consumer is popping in the same cycle.
  assign in_ready_o  = (r_count != FillW'(Depth));
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;
  assign w_write     = w_push & ~flush_i;

  fpnew_wrap_ptr #(.Depth(Depth)) u_wr_ptr (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_write),
    .i_clr (flush_i),
    .o_ptr (w_wr_ptr)
  );

  fpnew_wrap_ptr #(.Depth(Depth)) u_rd_ptr (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_pop & ~flush_i),
    .i_clr (flush_i),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write) begin
      r_mem[w_wr_ptr] <= '{result:        result_i,
                           status:        status_i,
                           extension_bit: extension_bit_i,
                           tag:           tag_i,
                           aux:           aux_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (flush_i) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FillW'(1);
        2'b01:   r_count <= r_count - FillW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign result_o        = r_mem[w_rd_ptr].result;
  assign status_o        = r_mem[w_rd_ptr].status;
  assign extension_bit_o = r_mem[w_rd_ptr].extension_bit;
  assign tag_o           = r_mem[w_rd_ptr].tag;
  assign aux_o           = r_mem[w_rd_ptr].aux;
  assign busy_o          = out_valid_o;
  assign fill_o          = r_count;

endmodule

// File: tb/tb_fpnew_pipe_out_fifo.sv
// tb/tb_fpnew_pipe_out_fifo.sv - self-checking bench for fpnew_pipe_out_fifo at Depth 2 and 3
module tb_fpnew_pipe_out_fifo;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  s;
    logic        e;
    logic [3:0]  t;
    logic [1:0]  a;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] res_i = '0;
  logic [4:0]  st_i = '0;
  logic        ext_i = 1'b0;
  logic [3:0]  tag_i = '0;
  logic [1:0]  aux_i = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic [31:0] d2_res, d3_res;
  logic [4:0]  d2_st, d3_st;
  logic        d2_ext, d3_ext;
  logic [3:0]  d2_tag, d3_tag;
  logic [1:0]  d2_aux, d3_aux;
  logic        d2_ov, d2_ir, d2_busy, d3_ov, d3_ir, d3_busy;
  logic [1:0]  d2_fill, d3_fill;

  ent_t q2[$];
  ent_t q3[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fpnew_pipe_out_fifo #(.Width(32), .Depth(2), .TagType(logic [3:0]), .AuxType(logic [1:0])) dut2 (
    .clk_i(clk), .rst_i(rst), .result_i(res_i), .status_i(st_i), .extension_bit_i(ext_i),
    .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid), .in_ready_o(d2_ir), .flush_i(flush),
    .result_o(d2_res), .status_o(d2_st), .extension_bit_o(d2_ext), .tag_o(d2_tag), .aux_o(d2_aux),
    .out_valid_o(d2_ov), .out_ready_i(out_ready), .busy_o(d2_busy), .fill_o(d2_fill));

  fpnew_pipe_out_fifo #(.Width(32), .Depth(3), .TagType(logic [3:0]), .AuxType(logic [1:0])) dut3 (
    .clk_i(clk), .rst_i(rst), .result_i(res_i), .status_i(st_i), .extension_bit_i(ext_i),
    .tag_i(tag_i), .aux_i(aux_i), .in_valid_i(in_valid), .in_ready_o(d3_ir), .flush_i(flush),
    .result_o(d3_res), .status_o(d3_st), .extension_bit_o(d3_ext), .tag_o(d3_tag), .aux_o(d3_aux),
    .out_valid_o(d3_ov), .out_ready_i(out_ready), .busy_o(d3_busy), .fill_o(d3_fill));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input string nm, input int depth, input int sz, input ent_t hd,
                         input ent_t act, input logic ov, input logic ir, input logic by,
                         input int fill);
    chk({nm, ".out_valid"}, 64'(ov), 64'(sz != 0));
    chk({nm, ".in_ready"}, 64'(ir), 64'(sz != depth));
    chk({nm, ".busy"}, 64'(by), 64'(sz != 0));
    chk({nm, ".fill"}, 64'(fill), 64'(sz));
    if (sz > 0) chk({nm, ".head"}, 64'(act), 64'(hd));
  endtask

  // Reference queues: bounded FIFOs of capacity 2 and 3.
  always @(posedge clk or posedge rst) begin
    ent_t cur;
    bit   pu, po;
    if (rst) begin
      q2.delete();
      q3.delete();
    end else begin
      cur = {res_i, st_i, ext_i, tag_i, aux_i};
      po = out_ready && (q2.size() > 0);
      pu = in_valid && (q2.size() < 2);
      if (flush) q2.delete();
      else begin
        if (po) void'(q2.pop_front());
        if (pu) q2.push_back(cur);
      end
      po = out_ready && (q3.size() > 0);
      pu = in_valid && (q3.size() < 3);
      if (flush) q3.delete();
      else begin
        if (po) void'(q3.pop_front());
        if (pu) q3.push_back(cur);
      end
    end
  end

  always @(negedge clk) begin
    cmp_dut("d2", 2, q2.size(), (q2.size() > 0) ? q2[0] : ent_t'('0),
            {d2_res, d2_st, d2_ext, d2_tag, d2_aux}, d2_ov, d2_ir, d2_busy, int'(d2_fill));
    cmp_dut("d3", 3, q3.size(), (q3.size() > 0) ? q3[0] : ent_t'('0),
            {d3_res, d3_st, d3_ext, d3_tag, d3_aux}, d3_ov, d3_ir, d3_busy, int'(d3_fill));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] s, input logic [3:0] t);
    in_valid = v;
    res_i    = r;
    st_i     = s;
    tag_i    = t;
    ext_i    = t[0];
    aux_i    = t[2:1];
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("rst.out_valid", 64'(d2_ov), 64'd0);
    chk("rst.in_ready", 64'(d2_ir), 64'd1);
    chk("rst.busy", 64'(d2_busy), 64'd0);
    chk("rst.fill", 64'(d2_fill), 64'd0);
    chk("rst.result", 64'(d2_res), 64'd0);
    chk("rst.d3_out_valid", 64'(d3_ov), 64'd0);

    drive(1'b1, 32'h3F80_0000, 5'b0, 4'd1);
    step();
    chk("push1.fill", 64'(d2_fill), 64'd1);
    chk("push1.result", 64'(d2_res), 64'h3F80_0000);
    drive(1'b1, 32'h4000_0000, 5'b0, 4'd2);
    step();
    chk("push2.fill", 64'(d2_fill), 64'd2);
    chk("push2.in_ready", 64'(d2_ir), 64'd0);
    drive(1'b1, 32'h4040_0000, 5'b0, 4'd4);
    step();
    chk("full.fill", 64'(d2_fill), 64'd2);
    chk("full.head_tag", 64'(d2_tag), 64'd1);
    chk("full.head_res", 64'(d2_res), 64'h3F80_0000);
    chk("d3.fill3", 64'(d3_fill), 64'd3);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("pop1.tag", 64'(d2_tag), 64'd2);
    chk("pop1.fill", 64'(d2_fill), 64'd1);
    chk("pop1.in_ready", 64'(d2_ir), 64'd1);
    step();
    chk("pop2.fill", 64'(d2_fill), 64'd0);
    chk("pop2.out_valid", 64'(d2_ov), 64'd0);

    out_ready = 1'b0;
    drive(1'b1, 32'h4080_0000, 5'b0, 4'd1);
    step();
    chk("pp.fill_before", 64'(d2_fill), 64'd1);
    drive(1'b1, 32'h40A0_0000, 5'b00001, 4'd3);
    out_ready = 1'b1;
    step();
    chk("pp.fill", 64'(d2_fill), 64'd1);
    chk("pp.tag", 64'(d2_tag), 64'd3);
    chk("pp.status", 64'(d2_st), 64'd1);
    chk("pp.result", 64'(d2_res), 64'h40A0_0000);
    in_valid = 1'b0;
    repeat (3) step();
    chk("drain.d2_fill", 64'(d2_fill), 64'd0);
    chk("drain.d3_fill", 64'(d3_fill), 64'd0);

    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 5'b0, 4'd5);
    step();
    drive(1'b1, 32'h2222_2222, 5'b0, 4'd6);
    step();
    chk("flush.pre_fill", 64'(d2_fill), 64'd2);
    drive(1'b1, 32'h7777_7777, 5'b0, 4'd7);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush.fill", 64'(d2_fill), 64'd0);
    chk("flush.out_valid", 64'(d2_ov), 64'd0);
    chk("flush.d3_fill", 64'(d3_fill), 64'd0);
    out_ready = 1'b1;
    step();
    chk("flush.no_ghost", 64'(d2_ov), 64'd0);

    for (int i = 0; i < 60; i++) begin
      drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 4'(i));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rand.d3_drained", 64'(d3_fill), 64'd0);

    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'b10000, 4'd9);
    step();
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(d2_ov), 64'd0);
    chk("arst.fill", 64'(d2_fill), 64'd0);
    chk("arst.in_ready", 64'(d2_ir), 64'd1);
    chk("arst.result", 64'(d2_res), 64'd0);
    chk("arst.d3_busy", 64'(d3_busy), 64'd0);
    #3 rst = 1'b0;
    step();
    chk("arst.after", 64'(d2_ov), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
